// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset decode: ALU commands, opcodes, condition
// codes, instruction classes, decoded control bundle and the NZCV condition test.
package arm_pkg;

  // ALU commands driven to EX
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  // CMP/TST reuse SUB/AND; loads and stores reuse ADD for address generation
  localparam logic [3:0] EXE_CMP = EXE_SUB;
  localparam logic [3:0] EXE_TST = EXE_AND;
  localparam logic [3:0] EXE_MEM = EXE_ADD;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition field, instr[31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Instruction class, instr[27:26]
  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Control bundle that gets squashed as a unit
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // True when the condition passes for flags {N,Z,C,V}
  function automatic logic cond_holds(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !c || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch/hazard/writeback inputs in, operands and control out to EX.
interface id_stage_if #(
  parameter int unsigned DATA_W = 32
);
  // From fetch, hazard unit, EX and writeback
  logic              freeze;
  logic              flush;
  logic              hazard;
  logic [31:0]       instruction_in;
  logic [DATA_W-1:0] PC_in;
  logic              wb_en_in;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [3:0]        status;
  // To EX and hazard unit
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] val_Rn;
  logic [DATA_W-1:0] val_Rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic              two_src;
  logic [3:0]        exe_cmd;
  logic              mem_read;
  logic              mem_write;
  logic              wb_en;
  logic              b;
  logic              s;

  // Decode stage side
  modport slave (
    input  freeze, flush, hazard, instruction_in, PC_in, wb_en_in, wb_dest, wb_value, status,
    output PC, val_Rn, val_Rm, imm, shift_operand, signed_imm_24, dest, src1, src2, two_src,
    output exe_cmd, mem_read, mem_write, wb_en, b, s
  );

  // Surrounding pipeline side
  modport master (
    output freeze, flush, hazard, instruction_in, PC_in, wb_en_in, wb_dest, wb_value, status,
    input  PC, val_Rn, val_Rm, imm, shift_operand, signed_imm_24, dest, src1, src2, two_src,
    input  exe_cmd, mem_read, mem_write, wb_en, b, s
  );
endinterface

// File: rtl/register_file.sv
// Register file: two asynchronous read ports with write-through, one write port,
// synchronous clear.
module register_file #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned IDX_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx1,
  input  logic [IDX_W-1:0]  i_rd_idx2,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2
);

  logic [DATA_W-1:0] r_regs [REG_CNT];

  // Storage: reset clears every entry and suppresses a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  // Bypass lets a writeback and a dependent decode share one cycle
  assign o_rd_data1 = (i_wr_en && (i_wr_idx == i_rd_idx1)) ? i_wr_data : r_regs[i_rd_idx1];
  assign o_rd_data2 = (i_wr_en && (i_wr_idx == i_rd_idx2)) ? i_wr_data : r_regs[i_rd_idx2];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, register file, control decode and
// condition evaluation feeding EX.
module id_stage
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16
) (
  input logic        clk,
  input logic        rst,
  id_stage_if.slave  bus
);

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_pc;

  cond_e       w_cond;
  mode_e       w_mode;
  logic        w_i_bit;
  logic [3:0]  w_opcode;
  logic        w_s_bit;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic [3:0]  w_rm;
  logic        w_is_str;
  logic [3:0]  w_src2;
  logic        w_ctrl_en;
  ctrl_t       w_ctrl;
  ctrl_t       w_ctrl_out;
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;

  // IF/ID capture: flush beats freeze, freeze holds every field
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (!bus.freeze) begin
      r_valid <= 1'b1;
      r_instr <= bus.instruction_in;
      r_pc    <= bus.PC_in;
    end
  end

  assign w_cond   = cond_e'(r_instr[31:28]);
  assign w_mode   = mode_e'(r_instr[27:26]);
  assign w_i_bit  = r_instr[25];
  assign w_opcode = r_instr[24:21];
  assign w_s_bit  = r_instr[20];
  assign w_rn     = r_instr[19:16];
  assign w_rd     = r_instr[15:12];
  assign w_rm     = r_instr[3:0];

  // A store reads its data register from the Rd field
  assign w_is_str = (w_mode == MODE_MEM) && !w_s_bit;
  assign w_src2   = w_is_str ? w_rd : w_rm;

  register_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_register_file (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx1  (w_rn),
    .i_rd_idx2  (w_src2),
    .i_wr_en    (bus.wb_en_in),
    .i_wr_idx   (bus.wb_dest),
    .i_wr_data  (bus.wb_value),
    .o_rd_data1 (w_val_rn),
    .o_rd_data2 (w_val_rm)
  );

  // Control decode from instruction class and opcode; unknown encodings stay all-zero
  always_comb begin
    w_ctrl = '0;
    case (w_mode)
      MODE_ARITH: begin
        case (w_opcode)
          OP_MOV: begin w_ctrl.exe_cmd = EXE_MOV; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_MVN: begin w_ctrl.exe_cmd = EXE_MVN; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_ADD: begin w_ctrl.exe_cmd = EXE_ADD; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_ADC: begin w_ctrl.exe_cmd = EXE_ADC; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_SUB: begin w_ctrl.exe_cmd = EXE_SUB; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_SBC: begin w_ctrl.exe_cmd = EXE_SBC; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_AND: begin w_ctrl.exe_cmd = EXE_AND; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_ORR: begin w_ctrl.exe_cmd = EXE_ORR; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_EOR: begin w_ctrl.exe_cmd = EXE_EOR; w_ctrl.wb_en = 1'b1; w_ctrl.s = w_s_bit; end
          OP_CMP: begin w_ctrl.exe_cmd = EXE_CMP; w_ctrl.s = w_s_bit; end
          OP_TST: begin w_ctrl.exe_cmd = EXE_TST; w_ctrl.s = w_s_bit; end
          default: w_ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        w_ctrl.exe_cmd = EXE_MEM;
        if (w_s_bit) begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.wb_en    = 1'b1;
        end else begin
          w_ctrl.mem_write = 1'b1;
        end
      end
      MODE_BRANCH: w_ctrl.b = 1'b1;
      default:     w_ctrl = '0;
    endcase
  end

  // Bubble, failed condition or hazard squash every control bit
  assign w_ctrl_en  = r_valid && cond_holds(w_cond, bus.status) && !bus.hazard;
  assign w_ctrl_out = w_ctrl_en ? w_ctrl : '0;

  assign bus.exe_cmd   = w_ctrl_out.exe_cmd;
  assign bus.mem_read  = w_ctrl_out.mem_read;
  assign bus.mem_write = w_ctrl_out.mem_write;
  assign bus.wb_en     = w_ctrl_out.wb_en;
  assign bus.b         = w_ctrl_out.b;
  assign bus.s         = w_ctrl_out.s;

  assign bus.PC            = r_pc;
  assign bus.val_Rn        = w_val_rn;
  assign bus.val_Rm        = w_val_rm;
  assign bus.imm           = w_i_bit;
  assign bus.shift_operand = r_instr[11:0];
  assign bus.signed_imm_24 = r_instr[23:0];
  assign bus.dest          = w_rd;
  assign bus.src1          = w_rn;
  assign bus.src2          = w_src2;
  // Gated by valid so a bubble never reports a second source to the hazard unit
  assign bus.two_src = r_valid &&
                       (((w_mode == MODE_ARITH) && !w_i_bit) || w_is_str);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed program plus random traffic, scoreboarded
// against a reference model of the IF/ID register, register file and decode.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32)) bus ();

  id_stage #(
    .DATA_W  (32),
    .REG_CNT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [3:0]  exe;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
  } exp_t;

  exp_t sb_q[$];

  // Reference state
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_regs [16];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf & !z;
      4'h9: return !cf | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive at negedge, compare 1ns later, then advance the model past the posedge
  task automatic cycle(input logic r, input logic fz, input logic fl, input logic hz,
                       input logic [3:0] st, input logic we, input logic [3:0] wd,
                       input logic [31:0] wv, input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    exp_t o;
    logic [1:0] mode;
    logic [3:0] op;
    logic       sb;
    logic       ib;
    logic       known;
    string      t;
    @(negedge clk);
    rst                = r;
    bus.freeze         = fz;
    bus.flush          = fl;
    bus.hazard         = hz;
    bus.status         = st;
    bus.wb_en_in       = we;
    bus.wb_dest        = wd;
    bus.wb_value       = wv;
    bus.instruction_in = ins;
    bus.PC_in          = pc;

    mode  = m_instr[27:26];
    ib    = m_instr[25];
    op    = m_instr[24:21];
    sb    = m_instr[20];
    e.pc    = m_pc;
    e.imm   = ib;
    e.shop  = m_instr[11:0];
    e.imm24 = m_instr[23:0];
    e.dest  = m_instr[15:12];
    e.src1  = m_instr[19:16];
    e.src2  = (mode == 2'b01 && !sb) ? m_instr[15:12] : m_instr[3:0];
    e.rn_val = (we && wd == e.src1) ? wv : m_regs[e.src1];
    e.rm_val = (we && wd == e.src2) ? wv : m_regs[e.src2];
    e.two_src = m_valid & ((mode == 2'b00 && !ib) || (mode == 2'b01 && !sb));
    e.exe = 4'h0; e.mr = 0; e.mw = 0; e.wb = 0; e.b = 0; e.s = 0;
    if (mode == 2'b00) begin
      known = 1'b1;
      e.wb  = 1'b1;
      case (op)
        4'b1101: e.exe = 4'b0001;
        4'b1111: e.exe = 4'b1001;
        4'b0100: e.exe = 4'b0010;
        4'b0101: e.exe = 4'b0011;
        4'b0010: e.exe = 4'b0100;
        4'b0110: e.exe = 4'b0101;
        4'b0000: e.exe = 4'b0110;
        4'b1100: e.exe = 4'b0111;
        4'b0001: e.exe = 4'b1000;
        4'b1010: begin e.exe = 4'b0100; e.wb = 1'b0; end
        4'b1000: begin e.exe = 4'b0110; e.wb = 1'b0; end
        default: begin known = 1'b0; e.wb = 1'b0; end
      endcase
      e.s = known & sb;
    end else if (mode == 2'b01) begin
      e.exe = 4'b0010;
      e.mr  = sb;
      e.wb  = sb;
      e.mw  = !sb;
    end else if (mode == 2'b10) begin
      e.b = 1'b1;
    end
    if (!m_valid || !m_cond(m_instr[31:28], st) || hz) begin
      e.exe = 4'h0; e.mr = 0; e.mw = 0; e.wb = 0; e.b = 0; e.s = 0;
    end
    sb_q.push_back(e);

    #1;
    t = $sformatf("c%0d", cyc);
    if (sb_q.size() == 0) begin
      check_eq({t, ".queue"}, 32'd0, 32'd1);
    end else begin
      o = sb_q.pop_front();
      check_eq({t, ".PC"}, bus.PC, o.pc);
      check_eq({t, ".val_Rn"}, bus.val_Rn, o.rn_val);
      check_eq({t, ".val_Rm"}, bus.val_Rm, o.rm_val);
      check_eq({t, ".imm"}, 32'(bus.imm), 32'(o.imm));
      check_eq({t, ".shift_operand"}, 32'(bus.shift_operand), 32'(o.shop));
      check_eq({t, ".signed_imm_24"}, 32'(bus.signed_imm_24), 32'(o.imm24));
      check_eq({t, ".dest"}, 32'(bus.dest), 32'(o.dest));
      check_eq({t, ".src1"}, 32'(bus.src1), 32'(o.src1));
      check_eq({t, ".src2"}, 32'(bus.src2), 32'(o.src2));
      check_eq({t, ".two_src"}, 32'(bus.two_src), 32'(o.two_src));
      check_eq({t, ".exe_cmd"}, 32'(bus.exe_cmd), 32'(o.exe));
      check_eq({t, ".mem_read"}, 32'(bus.mem_read), 32'(o.mr));
      check_eq({t, ".mem_write"}, 32'(bus.mem_write), 32'(o.mw));
      check_eq({t, ".wb_en"}, 32'(bus.wb_en), 32'(o.wb));
      check_eq({t, ".b"}, 32'(bus.b), 32'(o.b));
      check_eq({t, ".s"}, 32'(bus.s), 32'(o.s));
    end

    if (r) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    end else if (we) begin
      m_regs[wd] = wv;
    end
    if (r || fl) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
    end else if (!fz) begin
      m_valid = 1'b1; m_instr = ins; m_pc = pc;
    end
    cyc++;
  endtask

  localparam logic [31:0] I_MOV   = 32'hE3A00014;
  localparam logic [31:0] I_ADDS  = 32'hE0923002;
  localparam logic [31:0] I_ADDNE = 32'h10811001;
  localparam logic [31:0] I_STR   = 32'hE4801000;
  localparam logic [31:0] I_LDR   = 32'hE490B000;
  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_CMP   = 32'hE1520003;

  initial begin
    logic [31:0] ins;
    rst = 1'b1;
    bus.freeze = 0; bus.flush = 0; bus.hazard = 0; bus.status = 4'h0;
    bus.wb_en_in = 0; bus.wb_dest = 4'h0; bus.wb_value = 32'h0;
    bus.instruction_in = 32'h0; bus.PC_in = 32'h0;
    m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    repeat (2) @(posedge clk);

    // Reset bubble in ID
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_MOV, 32'd4);
    check_eq("rst.exe_cmd", 32'(bus.exe_cmd), 32'h0);
    check_eq("rst.PC", bus.PC, 32'h0);
    check_eq("rst.two_src", 32'(bus.two_src), 32'h0);
    // MOV R0,#20 in ID; write R4
    cycle(0, 0, 0, 0, 4'h0, 1, 4'd4, 32'd41, I_ADDS, 32'd8);
    check_eq("mov.exe_cmd", 32'(bus.exe_cmd), 32'h1);
    check_eq("mov.wb_en", 32'(bus.wb_en), 32'h1);
    check_eq("mov.imm", 32'(bus.imm), 32'h1);
    check_eq("mov.shift_operand", 32'(bus.shift_operand), 32'h014);
    check_eq("mov.PC", bus.PC, 32'd4);
    // ADDS R3,R2,R2 with a same-cycle writeback of R2
    cycle(0, 0, 0, 0, 4'h0, 1, 4'd2, 32'hC000_0000, I_ADDNE, 32'd12);
    check_eq("adds.val_Rn", bus.val_Rn, 32'hC000_0000);
    check_eq("adds.val_Rm", bus.val_Rm, 32'hC000_0000);
    check_eq("adds.s", 32'(bus.s), 32'h1);
    check_eq("adds.exe_cmd", 32'(bus.exe_cmd), 32'h2);
    check_eq("adds.two_src", 32'(bus.two_src), 32'h1);
    // ADDNE with Z=1 then Z=0
    cycle(0, 0, 0, 0, 4'b0100, 0, 4'h0, 32'h0, I_ADDNE, 32'd16);
    check_eq("addne_z1.wb_en", 32'(bus.wb_en), 32'h0);
    check_eq("addne_z1.exe_cmd", 32'(bus.exe_cmd), 32'h0);
    cycle(0, 0, 0, 0, 4'b0000, 0, 4'h0, 32'h0, I_STR, 32'd20);
    check_eq("addne_z0.wb_en", 32'(bus.wb_en), 32'h1);
    check_eq("addne_z0.exe_cmd", 32'(bus.exe_cmd), 32'h2);
    // STR then LDR
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_LDR, 32'd24);
    check_eq("str.mem_write", 32'(bus.mem_write), 32'h1);
    check_eq("str.wb_en", 32'(bus.wb_en), 32'h0);
    check_eq("str.src2", 32'(bus.src2), 32'h1);
    check_eq("str.two_src", 32'(bus.two_src), 32'h1);
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_ADD, 32'd28);
    check_eq("ldr.mem_read", 32'(bus.mem_read), 32'h1);
    check_eq("ldr.wb_en", 32'(bus.wb_en), 32'h1);
    check_eq("ldr.dest", 32'(bus.dest), 32'd11);
    // Freeze two cycles with changing fetch, then flush+freeze
    cycle(0, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0, 32'hDEADBEEF, 32'd32);
    check_eq("frz0.PC", bus.PC, 32'd28);
    cycle(0, 1, 0, 0, 4'h0, 0, 4'h0, 32'h0, 32'h12345678, 32'd36);
    check_eq("frz1.PC", bus.PC, 32'd28);
    check_eq("frz1.exe_cmd", 32'(bus.exe_cmd), 32'h2);
    cycle(0, 1, 1, 0, 4'h0, 0, 4'h0, 32'h0, 32'hE3A0F0FF, 32'd40);
    check_eq("frz2.dest", 32'(bus.dest), 32'h1);
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_ADD, 32'd44);
    check_eq("flush.PC", bus.PC, 32'h0);
    check_eq("flush.wb_en", 32'(bus.wb_en), 32'h0);
    // Hazard on a valid ADD
    cycle(0, 0, 0, 1, 4'h0, 0, 4'h0, 32'h0, I_CMP, 32'd48);
    check_eq("haz.exe_cmd", 32'(bus.exe_cmd), 32'h0);
    check_eq("haz.src1", 32'(bus.src1), 32'h2);
    check_eq("haz.val_Rn", bus.val_Rn, 32'hC000_0000);
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_ADD, 32'd52);
    check_eq("cmp.exe_cmd", 32'(bus.exe_cmd), 32'h4);
    check_eq("cmp.wb_en", 32'(bus.wb_en), 32'h0);
    // Reset mid-stream clears the register file
    cycle(1, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_ADD, 32'd56);
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, I_ADD, 32'd60);
    check_eq("post_rst.exe_cmd", 32'(bus.exe_cmd), 32'h0);
    cycle(0, 0, 0, 0, 4'h0, 0, 4'h0, 32'h0, 32'h0, 32'd64);
    check_eq("post_rst.val_Rn", bus.val_Rn, 32'h0);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
      cycle(($urandom_range(31, 0) == 0), ($urandom_range(5, 0) == 0),
            ($urandom_range(7, 0) == 0), ($urandom_range(5, 0) == 0),
            4'($urandom), 1'($urandom), 4'($urandom), $urandom, ins, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
